// File: rtl/template_db_bank.sv
// template_db_bank: double-buffered per-channel template words with deferred bank transfer.
module template_db_bank #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int AW = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [AW-1:0]             addr,
  input  logic [WIDTH-1:0]          d,
  input  logic                      transfer,
  input  logic                      rd_sel,
  input  logic [AW-1:0]             rd_addr,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [WIDTH-1:0]          rdata,
  output logic [CHANNELS-1:0]       dirty,
  output logic                      pending,
  output logic                      done,
  output logic                      addr_err
);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] stg [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] stg_flat, src;
  logic legal, rd_ok, xfer;
  assign legal = 32'(addr) < CHANNELS;
  assign rd_ok = 32'(rd_addr) < CHANNELS;
  assign pending = state == ARMED;
  // a transfer requested alongside a load waits for the first load-free edge
  always_comb begin
    xfer = (state == IDLE) ? transfer && !load : !load;
    state_n = (state == IDLE) ? ((transfer && load) ? ARMED : IDLE) : (load ? ARMED : IDLE);
    stg_flat = '0;
    for (int c = 0; c < CHANNELS; c++) stg_flat[c*WIDTH +: WIDTH] = stg[c];
    src = rd_sel ? q : stg_flat;
    rdata = rd_ok ? src[32'(rd_addr)*WIDTH +: WIDTH] : '0;
  end
  // all-ones templates keep the tristates disabled out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q <= '1;
      for (int c = 0; c < CHANNELS; c++) stg[c] <= '1;
      dirty <= '0;
      done <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state <= state_n;
      done <= xfer;
      for (int c = 0; c < CHANNELS; c++) if (load && 32'(addr) == c) stg[c] <= d;
      if (xfer) q <= stg_flat;
      dirty <= xfer ? '0 : dirty | ((load && legal) ? CHANNELS'(1) << addr : '0);
      if (load && !legal) addr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_template_db_bank.sv
// tb_template_db_bank: directed vector table plus hand sequences for reset, collision and address errors.
module tb_template_db_bank;
  logic clk = 1'b0, rst, load, transfer, rd_sel;
  logic [1:0] addr, rd_addr;
  logic [7:0] d;
  logic [31:0] q;
  logic [7:0] rdata;
  logic [3:0] dirty;
  logic pending, done, addr_err;
  logic [23:0] q3;
  logic [7:0] rdata3;
  logic [2:0] dirty3;
  logic pending3, done3, addr_err3;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  template_db_bank #(.WIDTH(8), .CHANNELS(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .load(load), .addr(addr), .d(d), .transfer(transfer),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .q(q), .rdata(rdata), .dirty(dirty),
    .pending(pending), .done(done), .addr_err(addr_err));

  template_db_bank #(.WIDTH(8), .CHANNELS(3), .AW(2)) dut3 (
    .clk(clk), .rst(rst), .load(load), .addr(addr), .d(d), .transfer(transfer),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .q(q3), .rdata(rdata3), .dirty(dirty3),
    .pending(pending3), .done(done3), .addr_err(addr_err3));

  typedef struct {
    logic ld; logic [1:0] a; logic [7:0] dd; logic tr; logic rs; logic [1:0] ra;
    logic [31:0] eq; logic [3:0] edirty; logic epend; logic edone; logic [7:0] erd;
  } vec_t;
  vec_t v[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic r, input logic l, input logic [1:0] a, input logic [7:0] dd,
                       input logic t, input logic rs, input logic [1:0] ra);
    rst = r; load = l; addr = a; d = dd; transfer = t; rd_sel = rs; rd_addr = ra;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    v[0]  = '{1'b1, 2'd1, 8'h3C, 1'b0, 1'b0, 2'd1, 32'hFFFFFFFF, 4'b0010, 1'b0, 1'b0, 8'h3C};
    v[1]  = '{1'b1, 2'd3, 8'hA5, 1'b0, 1'b0, 2'd3, 32'hFFFFFFFF, 4'b1010, 1'b0, 1'b0, 8'hA5};
    v[2]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd3, 32'hA5FF3CFF, 4'b0000, 1'b0, 1'b1, 8'hA5};
    v[3]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 32'hA5FF3CFF, 4'b0000, 1'b0, 1'b0, 8'h3C};
    v[4]  = '{1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 2'd0, 32'hA5FF3CFF, 4'b0001, 1'b1, 1'b0, 8'h11};
    v[5]  = '{1'b1, 2'd2, 8'h22, 1'b0, 1'b0, 2'd2, 32'hA5FF3CFF, 4'b0101, 1'b1, 1'b0, 8'h22};
    v[6]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 32'hA5223C11, 4'b0000, 1'b0, 1'b1, 8'h11};
    v[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 32'hA5223C11, 4'b0000, 1'b0, 1'b0, 8'h22};
    v[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd3, 32'hA5223C11, 4'b0000, 1'b0, 1'b1, 8'hA5};
    v[9]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd3, 32'hA5223C11, 4'b0000, 1'b0, 1'b1, 8'hA5};
    v[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd3, 32'hA5223C11, 4'b0000, 1'b0, 1'b0, 8'hA5};
    v[11] = '{1'b1, 2'd2, 8'h5A, 1'b0, 1'b0, 2'd2, 32'hA5223C11, 4'b0100, 1'b0, 1'b0, 8'h5A};
    v[12] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 32'hA5223C11, 4'b0100, 1'b0, 1'b0, 8'h22};
    v[13] = '{1'b1, 2'd0, 8'h77, 1'b1, 1'b0, 2'd0, 32'hA5223C11, 4'b0101, 1'b1, 1'b0, 8'h77};
    v[14] = '{1'b1, 2'd1, 8'h88, 1'b1, 1'b0, 2'd1, 32'hA5223C11, 4'b0111, 1'b1, 1'b0, 8'h88};
    v[15] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd1, 32'hA55A8877, 4'b0000, 1'b0, 1'b1, 8'h88};
    v[16] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 32'hA55A8877, 4'b0000, 1'b0, 1'b0, 8'h77};

    drive(1'b1, 1'b1, 2'd2, 8'h00, 1'b1, 1'b0, 2'd2);
    @(negedge clk);
    step();
    check("rst_q", q, 32'hFFFFFFFF);
    check("rst_rdata", {24'h0, rdata}, 32'hFF);
    check("rst_dirty", {28'h0, dirty}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_pending", {31'h0, pending}, 32'h0);
    check("rst_addr_err", {31'h0, addr_err}, 32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(1'b0, v[i].ld, v[i].a, v[i].dd, v[i].tr, v[i].rs, v[i].ra);
      step();
      check($sformatf("v%0d_q", i), q, v[i].eq);
      check($sformatf("v%0d_dirty", i), {28'h0, dirty}, {28'h0, v[i].edirty});
      check($sformatf("v%0d_pending", i), {31'h0, pending}, {31'h0, v[i].epend});
      check($sformatf("v%0d_done", i), {31'h0, done}, {31'h0, v[i].edone});
      check($sformatf("v%0d_rdata", i), {24'h0, rdata}, {24'h0, v[i].erd});
    end

    drive(1'b0, 1'b1, 2'd0, 8'h33, 1'b1, 1'b0, 2'd0);
    step();
    check("armed_pending", {31'h0, pending}, 32'h1);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0);
    step();
    check("midrst_pending", {31'h0, pending}, 32'h0);
    check("midrst_q", q, 32'hFFFFFFFF);
    check("midrst_done", {31'h0, done}, 32'h0);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("midrst_nodone%0d", i), {31'h0, done}, 32'h0);
    end

    drive(1'b0, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b0, 2'd2);
    step();
    check("rb_staging", {24'h0, rdata}, 32'h5A);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2);
    #1;
    check("rb_active", {24'h0, rdata}, 32'hFF);
    rd_addr = 2'd3;
    #1;
    check("rb_oor3", {24'h0, rdata3}, 32'h0);

    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0);
    step();
    drive(1'b0, 1'b1, 2'd3, 8'h99, 1'b0, 1'b0, 2'd3);
    step();
    check("ill_addr_err", {31'h0, addr_err3}, 32'h1);
    check("ill_dirty", {29'h0, dirty3}, 32'h0);
    check("ill_rdata_oor", {24'h0, rdata3}, 32'h0);
    rd_addr = 2'd0;
    #1;
    check("ill_stg0", {24'h0, rdata3}, 32'hFF);
    drive(1'b0, 1'b1, 2'd1, 8'h42, 1'b0, 1'b0, 2'd1);
    step();
    check("ill_sticky1", {31'h0, addr_err3}, 32'h1);
    check("ill_legal_dirty", {29'h0, dirty3}, 32'h2);
    check("ill_legal_rdata", {24'h0, rdata3}, 32'h42);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd1);
    step();
    check("ill_sticky2", {31'h0, addr_err3}, 32'h1);
    check("ill_q3", {8'h0, q3}, 32'hFF42FF);
    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0);
    step();
    check("ill_rst_clear", {31'h0, addr_err3}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/template_db_bank.md
TEMPLATE_DB_BANK -- requirements
Module: template_db_bank

Interface
REQ-001 Parameter WIDTH, default 8: bits per channel template word; legal range 1..32.
REQ-002 Parameter CHANNELS, default 4: number of double-buffered channels; legal range 2..16.
REQ-003 Parameter AW, default 2: address width; SHALL satisfy 2**AW >= CHANNELS.
REQ-004 CLK  input  1: the single clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1: synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-006 LOAD  input  1: write D into the staging word of channel ADDR.
REQ-007 ADDR  input  AW: channel select for LOAD.
REQ-008 D  input  WIDTH: staging write data.
REQ-009 TRANSFER  input  1: request to copy all staging words to the active outputs.
REQ-010 RD_SEL  input  1: readback source select; 0 = staging, 1 = active.
REQ-011 RD_ADDR  input  AW: readback channel select.
REQ-012 Q  output  CHANNELS*WIDTH: active words, registered; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-013 RDATA  output  WIDTH: combinational readback of the word selected by RD_SEL and RD_ADDR; all zeros when RD_ADDR >= CHANNELS.
REQ-014 DIRTY  output  CHANNELS: registered; bit c is set while staging c has been loaded but not yet transferred.
REQ-015 PENDING  output  1: registered; high while a transfer request is deferred.
REQ-016 DONE  output  1: registered; single-cycle pulse after each executed transfer.
REQ-017 ADDR_ERR  output  1: sticky flag set by a LOAD with ADDR >= CHANNELS.

Function
REQ-018 The control FSM SHALL have exactly two states: IDLE and ARMED.
REQ-019 A LOAD with a legal ADDR SHALL write D to staging[ADDR] at that edge and set DIRTY[ADDR].
REQ-020 A LOAD with an illegal ADDR SHALL leave all staging words and DIRTY unchanged and SHALL set ADDR_ERR.
REQ-021 In IDLE, an edge with TRANSFER=1 and LOAD=0 SHALL execute a transfer.
REQ-022 A transfer SHALL copy every staging word into Q simultaneously, clear all DIRTY bits, and drive DONE=1 for the following cycle only.
REQ-023 In IDLE, an edge with TRANSFER=1 and LOAD=1 SHALL perform the load, not the transfer, and SHALL move the FSM to ARMED with PENDING=1.
REQ-024 In ARMED, the first edge with LOAD=0 SHALL execute the transfer, return the FSM to IDLE, and clear PENDING.
REQ-025 In ARMED, further TRANSFER pulses SHALL merge into the single pending transfer, giving exactly one DONE.
REQ-026 A deferred transfer SHALL include every load made up to and including the last edge with LOAD=1.
REQ-027 Q SHALL change only on a transfer edge or on reset, never on LOAD alone.
REQ-028 DONE SHALL be 0 on every cycle that does not immediately follow a transfer edge.
REQ-029 Back-to-back transfers on consecutive edges SHALL each execute and SHALL hold DONE high continuously.
REQ-030 When the data is unchanged, a transfer SHALL still pulse DONE and SHALL leave Q unchanged.

Reset
REQ-031 While RST=1 at an edge, Q and all staging words SHALL become all ones, because active-high template bits disable the internal tristates and the block must never drive a DUT output after reset.
REQ-032 On the same reset edge, DIRTY SHALL become 0, PENDING 0, DONE 0, ADDR_ERR 0, and the FSM SHALL go to IDLE.
REQ-033 RST SHALL take priority over LOAD and TRANSFER on the same edge.
REQ-034 A reset while ARMED SHALL discard the pending transfer; no DONE SHALL follow the reset.

Verification
REQ-035 Reset: assert RST for 1 cycle with LOAD=1 and TRANSFER=1 (WIDTH=8, CHANNELS=4) -> Q=0xFFFFFFFF, RDATA (RD_SEL=0, RD_ADDR=2)=0xFF, DIRTY=0, DONE=0.
REQ-036 Basic load and transfer: LOAD ch1=0x3C, then LOAD ch3=0xA5 -> Q unchanged and DIRTY=4'b1010; then TRANSFER -> Q=0xA5FF3CFF, DONE=1 for exactly one cycle, DIRTY=0.
REQ-037 Collision: LOAD ch0=0x11 with TRANSFER on the same edge, then LOAD ch2=0x22, then LOAD idle -> PENDING=1 for 2 cycles; transfer executes on the first LOAD=0 edge with Q[7:0]=0x11 and Q[23:16]=0x22; exactly one DONE.
REQ-038 Illegal address: LOAD with ADDR=3 and CHANNELS=3 -> ADDR_ERR=1 and remains 1; staging and DIRTY unchanged; only RST clears ADDR_ERR.
REQ-039 Reset mid-operation: enter ARMED, then assert RST -> PENDING=0, Q=all ones, and no DONE pulse within the following 5 cycles.
REQ-040 Readback: after loading ch2=0x5A without a transfer -> RDATA=0x5A with RD_SEL=0 and 0xFF with RD_SEL=1; RD_ADDR >= CHANNELS -> RDATA=0x00.
